// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width and the transmit-queue launch FSM states.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    TXQ_IDLE = 2'd0,
    TXQ_ACK  = 2'd1,
    TXQ_DONE = 2'd2
  } txq_state_t;

endpackage

// File: rtl/uart_tx_queue_if.sv
// Producer-side valid/ready write handshake into the UART transmit queue.
interface uart_tx_queue_if;
  import uart_pkg::*;

  logic                   wr_valid;
  logic [UART_BYTE_W-1:0] wr_data;
  logic                   wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);

endinterface

// File: rtl/uart_txq_fifo.sv
// Power-of-two byte FIFO for the UART transmit queue: storage, pointers, registered level/full/empty and flush.
module uart_txq_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_wrValid,
  input  logic [UART_BYTE_W-1:0] i_wrData,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic [UART_BYTE_W-1:0] o_rdData,
  output logic [AW:0]            o_level,
  output logic                   o_empty,
  output logic                   o_full,
  output logic                   o_wrReady
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [UART_BYTE_W-1:0] r_mem [DEPTH];
  logic [AW:0]            r_wrPtr;
  logic [AW:0]            r_rdPtr;
  logic [AW:0]            r_level;
  logic                   r_empty;
  logic                   r_full;
  logic                   r_wrReady;

  logic                   w_push;
  logic [AW:0]            w_wrNext;
  logic [AW:0]            w_rdNext;
  logic [AW:0]            w_levelNext;

  assign w_push   = i_wrValid && r_wrReady && !i_flush;
  assign w_rdNext = i_pop ? r_rdPtr + PTR_ONE : r_rdPtr;
  // Flush snaps to the post-pop read pointer so a launch on the same edge still leaves level at zero.
  assign w_wrNext = i_flush ? w_rdNext : (w_push ? r_wrPtr + PTR_ONE : r_wrPtr);
  assign w_levelNext = w_wrNext - w_rdNext;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wrPtr[AW-1:0]] <= i_wrData;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_level   <= '0;
      r_empty   <= 1'b1;
      r_full    <= 1'b0;
      r_wrReady <= 1'b1;
    end else begin
      r_wrPtr   <= w_wrNext;
      r_rdPtr   <= w_rdNext;
      r_level   <= w_levelNext;
      r_empty   <= (w_wrNext == w_rdNext);
      r_full    <= (w_wrNext[AW] != w_rdNext[AW]) &&
                   (w_wrNext[AW-1:0] == w_rdNext[AW-1:0]);
      r_wrReady <= !((w_wrNext[AW] != w_rdNext[AW]) &&
                     (w_wrNext[AW-1:0] == w_rdNext[AW-1:0]));
    end
  end

  assign o_rdData  = r_mem[r_rdPtr[AW-1:0]];
  assign o_level   = r_level;
  assign o_empty   = r_empty;
  assign o_full    = r_full;
  assign o_wrReady = r_wrReady;

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue and launch sequencer feeding uart_tx: FIFO plus a start/busy handshake FSM.
// Optional sticky overflow flag (ovf/ovf_clr ports) is built only when UART_TXQ_OVF_EN is defined.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  uart_tx_queue_if.slave         wr,
  input  logic                   flush,
  output logic                   tx_start,
  output logic [UART_BYTE_W-1:0] tx_data,
  input  logic                   tx_busy,
  output logic [AW:0]            level,
  output logic                   empty,
  output logic                   full
`ifdef UART_TXQ_OVF_EN
  ,
  output logic                   ovf,
  input  logic                   ovf_clr
`endif
);

  txq_state_t             r_state;
  txq_state_t             w_stateNext;
  logic                   r_txStart;
  logic [UART_BYTE_W-1:0] r_txData;
  logic                   w_startNext;
  logic [UART_BYTE_W-1:0] w_dataNext;
  logic                   w_pop;
  logic [UART_BYTE_W-1:0] w_rdData;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_wrReady;

  uart_txq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .i_wrValid (wr.wr_valid),
    .i_wrData  (wr.wr_data),
    .i_pop     (w_pop),
    .i_flush   (flush),
    .o_rdData  (w_rdData),
    .o_level   (level),
    .o_empty   (w_empty),
    .o_full    (w_full),
    .o_wrReady (w_wrReady)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= TXQ_IDLE;
      r_txStart <= 1'b0;
      r_txData  <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_txStart <= w_startNext;
      r_txData  <= w_dataNext;
    end
  end

  // A launch pops the head and latches it; tx_data then holds until the next launch, whatever flush does.
  always_comb begin
    w_stateNext = r_state;
    w_startNext = 1'b0;
    w_dataNext  = r_txData;
    w_pop       = 1'b0;
    case (r_state)
      TXQ_IDLE: begin
        if (!w_empty && !tx_busy) begin
          w_pop       = 1'b1;
          w_startNext = 1'b1;
          w_dataNext  = w_rdData;
          w_stateNext = TXQ_ACK;
        end
      end
      TXQ_ACK: begin
        if (tx_busy) begin
          w_stateNext = TXQ_DONE;
        end
      end
      TXQ_DONE: begin
        if (!tx_busy) begin
          w_stateNext = TXQ_IDLE;
        end
      end
      default: w_stateNext = TXQ_IDLE;
    endcase
  end

  assign tx_start    = r_txStart;
  assign tx_data     = r_txData;
  assign empty       = w_empty;
  assign full        = w_full;
  assign wr.wr_ready = w_wrReady;

`ifdef UART_TXQ_OVF_EN
  logic r_ovf;

  // Setting takes priority over clearing so an overflow on the clear edge is never lost.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (wr.wr_valid && w_full && !flush) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed testbench for uart_tx_queue with a small behavioural uart_tx busy model.
module tb_uart_tx_queue;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);
  localparam int FRAME = 6;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        holdBusy;
  logic        txBusy;
  logic        txStart;
  logic [7:0]  txData;
  logic [AW:0] level;
  logic        empty;
  logic        full;
`ifdef UART_TXQ_OVF_EN
  logic        ovf;
  logic        ovfClr;
`endif

  logic [3:0]  busyCnt;
  logic [7:0]  launched[$];
  int          busyViol = 0;
  int          testCount = 0;
  int          failCount = 0;
  int          accepted;
  int          fullSeen;

  uart_tx_queue_if bus();

  uart_tx_queue #(.DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .wr       (bus),
    .flush    (flush),
    .tx_start (txStart),
    .tx_data  (txData),
    .tx_busy  (txBusy),
    .level    (level),
    .empty    (empty),
    .full     (full)
`ifdef UART_TXQ_OVF_EN
    ,
    .ovf      (ovf),
    .ovf_clr  (ovfClr)
`endif
  );

  always #5 clock = ~clock;

  // Transmitter stand-in: busy rises the edge after start and stays high for FRAME clocks.
  always @(posedge clock or posedge reset) begin
    if (reset) busyCnt <= 4'd0;
    else if (txStart) busyCnt <= 4'(FRAME);
    else if (busyCnt != 4'd0) busyCnt <= busyCnt - 4'd1;
  end
  assign txBusy = (busyCnt != 4'd0) || holdBusy;

  always @(posedge clock) begin
    if (!reset && txStart) begin
      launched.push_back(txData);
      if (txBusy) busyViol <= busyViol + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic applyStimulus(input logic [7:0] first, input int n);
    accepted = 0;
    fullSeen = 0;
    for (int i = 0; i < n; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = first + 8'(i);
      if (bus.wr_ready) accepted++;
      if (full) fullSeen++;
      @(negedge clock);
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic waitDrain(input string tag);
    int quiet = 0;
    int budget = 0;
    while (quiet < 3 && budget < 600) begin
      @(negedge clock);
      budget++;
      if (empty && !txBusy && !txStart) quiet++;
      else quiet = 0;
    end
    checkOutput(tag, 32'(quiet >= 3), 32'd1);
  endtask

  function automatic int orderErrors(input int base, input logic [7:0] first, input int n);
    int errs = 0;
    for (int i = 0; i < n; i++) begin
      if (base + i >= launched.size()) errs++;
      else if (launched[base + i] != first + 8'(i)) errs++;
    end
    return errs;
  endfunction

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    reset        = 1'b1;
    flush        = 1'b0;
    holdBusy     = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = 8'h00;
`ifdef UART_TXQ_OVF_EN
    ovfClr       = 1'b0;
`endif
    step(3);
    checkOutput("rst_tx_start", txStart, 1'b0);
    checkOutput("rst_tx_data", txData, 8'h00);
    checkOutput("rst_wr_ready", bus.wr_ready, 1'b1);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_empty", empty, 1'b1);
    checkOutput("rst_full", full, 1'b0);
`ifdef UART_TXQ_OVF_EN
    checkOutput("rst_ovf", ovf, 1'b0);
`endif
    reset = 1'b0;
    step(1);

    // Single byte: launch two edges after the write.
    base = launched.size();
    applyStimulus(8'hA5, 1);
    checkOutput("single_level_k", level, 1);
    checkOutput("single_empty_k", empty, 1'b0);
    checkOutput("single_start_k", txStart, 1'b0);
    step(1);
    checkOutput("single_start_k1", txStart, 1'b1);
    checkOutput("single_data_k1", txData, 8'hA5);
    checkOutput("single_empty_k1", empty, 1'b1);
    checkOutput("single_level_k1", level, 0);
    step(1);
    checkOutput("single_start_k2", txStart, 1'b0);
    checkOutput("single_data_k2", txData, 8'hA5);
    checkOutput("single_busy_k2", txBusy, 1'b1);
    waitDrain("single_drain");
    checkOutput("single_count", launched.size() - base, 1);
    checkOutput("single_order", orderErrors(base, 8'hA5, 1), 0);

    // Burst of 16 while draining.
    base = launched.size();
    applyStimulus(8'h01, 16);
    checkOutput("burst_accepted", accepted, 16);
    checkOutput("burst_full_le1", 32'(fullSeen <= 1), 1);
    waitDrain("burst_drain");
    checkOutput("burst_count", launched.size() - base, 16);
    checkOutput("burst_order", orderErrors(base, 8'h01, 16), 0);
    checkOutput("burst_busy_viol", busyViol, 0);

    // Overflow with the transmitter held busy.
    holdBusy = 1'b1;
    base = launched.size();
    applyStimulus(8'h20, 17);
    checkOutput("ovf_accepted", accepted, 16);
    checkOutput("ovf_level", level, 16);
    checkOutput("ovf_full", full, 1'b1);
    checkOutput("ovf_wr_ready", bus.wr_ready, 1'b0);
    checkOutput("ovf_no_launch", launched.size() - base, 0);
`ifdef UART_TXQ_OVF_EN
    checkOutput("ovf_set", ovf, 1'b1);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'hEE;
    ovfClr       = 1'b1;
    step(1);
    checkOutput("ovf_set_wins", ovf, 1'b1);
    bus.wr_valid = 1'b0;
    step(1);
    ovfClr = 1'b0;
    checkOutput("ovf_cleared", ovf, 1'b0);
    checkOutput("ovf_level_after", level, 16);
`endif
    holdBusy = 1'b0;
    waitDrain("ovf_drain");
    checkOutput("ovf_count", launched.size() - base, 16);
    checkOutput("ovf_order", orderErrors(base, 8'h20, 16), 0);

    // Push on the launch edge keeps level.
    holdBusy = 1'b1;
    base = launched.size();
    applyStimulus(8'h40, 3);
    checkOutput("pp_level_before", level, 3);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h43;
    holdBusy     = 1'b0;
    step(1);
    bus.wr_valid = 1'b0;
    checkOutput("pp_level", level, 3);
    checkOutput("pp_start", txStart, 1'b1);
    checkOutput("pp_data", txData, 8'h40);
    waitDrain("pp_drain");
    checkOutput("pp_count", launched.size() - base, 4);
    checkOutput("pp_order", orderErrors(base, 8'h40, 4), 0);

    // Flush during a frame; same-edge write is discarded.
    holdBusy = 1'b1;
    base = launched.size();
    applyStimulus(8'h50, 4);
    checkOutput("fl_level_before", level, 4);
    holdBusy = 1'b0;
    step(3);
    flush        = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h99;
    step(1);
    flush        = 1'b0;
    bus.wr_valid = 1'b0;
    checkOutput("fl_level", level, 0);
    checkOutput("fl_empty", empty, 1'b1);
    checkOutput("fl_data_held", txData, 8'h50);
    checkOutput("fl_wr_ready", bus.wr_ready, 1'b1);
    waitDrain("fl_drain");
    checkOutput("fl_count", launched.size() - base, 1);
    checkOutput("fl_order", orderErrors(base, 8'h50, 1), 0);

    // Flush on the launch edge still launches the head byte.
    holdBusy = 1'b1;
    base = launched.size();
    applyStimulus(8'h60, 2);
    holdBusy = 1'b0;
    flush    = 1'b1;
    step(1);
    flush = 1'b0;
    checkOutput("flp_start", txStart, 1'b1);
    checkOutput("flp_data", txData, 8'h60);
    checkOutput("flp_level", level, 0);
    checkOutput("flp_empty", empty, 1'b1);
    waitDrain("flp_drain");
    checkOutput("flp_count", launched.size() - base, 1);

    // Asynchronous reset while the FSM waits in DONE.
    applyStimulus(8'h70, 2);
    step(3);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rmid_tx_start", txStart, 1'b0);
    checkOutput("rmid_tx_data", txData, 8'h00);
    checkOutput("rmid_level", level, 0);
    checkOutput("rmid_empty", empty, 1'b1);
    checkOutput("rmid_full", full, 1'b0);
    checkOutput("rmid_wr_ready", bus.wr_ready, 1'b1);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(8'h72, 1);
    checkOutput("rmid_accept", accepted, 1);
    step(1);
    checkOutput("rmid_relaunch_start", txStart, 1'b1);
    checkOutput("rmid_relaunch_data", txData, 8'h72);
    waitDrain("rmid_drain");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
